// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns execute-stage d_mem_* strobes into a req/ack memory handshake
// with a bus timeout and sticky error flags. Define DMEM_POSTED_WR_EN for a 1-entry posted write buffer.
module dmem_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              d_mem_en,
   input  logic              d_mem_rd,
   input  logic              d_mem_wr,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_data_out,
   output logic [DATA_W-1:0] d_mem_data_in,
   output logic              dmem_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              err_clr,
   output logic [1:0]        err
);

`ifdef DMEM_POSTED_WR_EN
   localparam logic LP_POSTED = 1'b1;
`else
   localparam logic LP_POSTED = 1'b0;
`endif

   localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_posted;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_dataIn;
   logic [1:0]        r_err;

   logic              w_access;
   logic [7:0]        w_cntNext;
   logic              w_timeout;
   logic              w_stall;
   logic [1:0]        w_errSet;

   assign w_access  = d_mem_en & (d_mem_rd | d_mem_wr);
   assign w_cntNext = r_cnt + 8'd1;
   assign w_timeout = (w_cntNext == LP_TIMEOUT);

   // rd/wr both high or both low is a protocol error; so is an ack arriving outside REQ.
   assign w_errSet[0] = (r_state == ST_REQ) & ~mem_ack & w_timeout;
   assign w_errSet[1] = ((r_state == ST_IDLE) & d_mem_en & ~(d_mem_rd ^ d_mem_wr))
                      | (mem_ack & (r_state != ST_REQ));

   // A posted write frees the requester at once; anything behind it waits for the drain.
   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         ST_IDLE: w_stall = w_access & ~(LP_POSTED & d_mem_wr);
         ST_REQ:  w_stall = r_posted ? w_access : 1'b1;
         ST_RESP: w_stall = r_posted & w_access;
         default: w_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_posted <= 1'b0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_dataIn <= '0;
         r_err    <= 2'b00;
      end else begin
         r_err <= (r_err & ~{2{err_clr}}) | w_errSet;
         case (r_state)
            ST_IDLE: begin
               if (w_access) begin
                  r_addr   <= d_mem_addr;
                  r_wdata  <= d_mem_data_out;
                  r_we     <= d_mem_wr;
                  r_posted <= LP_POSTED & d_mem_wr;
                  r_req    <= 1'b1;
                  r_cnt    <= 8'd0;
                  r_state  <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_cnt <= w_cntNext;
               if (mem_ack) begin
                  r_req <= 1'b0;
                  if (!r_we) begin
                     r_dataIn <= mem_rdata;
                  end
                  r_state <= ST_RESP;
               end else if (w_timeout) begin
                  r_req <= 1'b0;
                  if (!r_we) begin
                     r_dataIn <= '1;
                  end
                  r_state <= ST_RESP;
               end
            end
            // The request still held here is the one just completed, so it is not reissued.
            ST_RESP: begin
               r_posted <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign d_mem_data_in = r_dataIn;
   assign dmem_stall    = w_stall;
   assign mem_req       = r_req;
   assign mem_we        = r_we;
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_wdata;
   assign err           = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: reads, writes, timeout, protocol errors and
// async reset mid-access. Inputs change on the falling edge; outputs are sampled just after it.
module tb_dmem_ctrl;

   logic        clk;
   logic        reset_;
   logic        d_mem_en;
   logic        d_mem_rd;
   logic        d_mem_wr;
   logic [11:0] d_mem_addr;
   logic [7:0]  d_mem_data_out;
   logic [7:0]  d_mem_data_in;
   logic        dmem_stall;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        err_clr;
   logic [1:0]  err;

   int tests;
   int failed;
   int stallCycles;
   int reqPulses;
   int stallBase;
   int reqBase;

   dmem_ctrl #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(15)) dut (
      .clk            (clk),
      .reset_         (reset_),
      .d_mem_en       (d_mem_en),
      .d_mem_rd       (d_mem_rd),
      .d_mem_wr       (d_mem_wr),
      .d_mem_addr     (d_mem_addr),
      .d_mem_data_out (d_mem_data_out),
      .d_mem_data_in  (d_mem_data_in),
      .dmem_stall     (dmem_stall),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .err_clr        (err_clr),
      .err            (err)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts the clock edges at which the requester is held, and the number of distinct memory requests.
   always @(posedge clk) begin
      if (dmem_stall === 1'b1) stallCycles++;
   end

   always @(posedge mem_req) begin
      reqPulses++;
   end

   task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                                input logic [11:0] addr, input logic [7:0] wdata);
      d_mem_en       = en;
      d_mem_rd       = rd;
      d_mem_wr       = wr;
      d_mem_addr     = addr;
      d_mem_data_out = wdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to the next falling edge and let combinational outputs settle.
   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      tests       = 0;
      failed      = 0;
      stallCycles = 0;
      reqPulses   = 0;
      reset_      = 1'b0;
      mem_ack     = 1'b0;
      mem_rdata   = 8'h00;
      err_clr     = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);

      #12;
      checkOutput("reset_mem_req", mem_req, 0);
      checkOutput("reset_mem_we", mem_we, 0);
      checkOutput("reset_mem_addr", mem_addr, 0);
      checkOutput("reset_mem_wdata", mem_wdata, 0);
      checkOutput("reset_data_in", d_mem_data_in, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_stall", dmem_stall, 0);
      @(negedge clk);
      reset_ = 1'b1;
      nextCycle();

      // Read 0x123, ack arrives in the third REQ cycle.
      stallBase = stallCycles;
      reqBase   = reqPulses;
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h123, 8'h00);
      #1;
      checkOutput("rd_idle_stall", dmem_stall, 1);
      nextCycle();
      checkOutput("rd_req1_mem_req", mem_req, 1);
      checkOutput("rd_req1_mem_we", mem_we, 0);
      checkOutput("rd_req1_mem_addr", mem_addr, 12'h123);
      checkOutput("rd_req1_stall", dmem_stall, 1);
      nextCycle();
      checkOutput("rd_req2_mem_req", mem_req, 1);
      nextCycle();
      mem_ack   = 1'b1;
      mem_rdata = 8'h5A;
      #1;
      checkOutput("rd_req3_stall", dmem_stall, 1);
      nextCycle();
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      #1;
      checkOutput("rd_resp_stall", dmem_stall, 0);
      checkOutput("rd_resp_data", d_mem_data_in, 8'h5A);
      checkOutput("rd_resp_mem_req", mem_req, 0);
      checkOutput("rd_stall_cycles", stallCycles - stallBase, 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      nextCycle();
      nextCycle();
      checkOutput("rd_req_pulses", reqPulses - reqBase, 1);
      checkOutput("rd_idle_mem_req", mem_req, 0);

      // Write 0xA5 to 0xFFF, ack in the first REQ cycle.
      stallBase = stallCycles;
      applyStimulus(1'b1, 1'b0, 1'b1, 12'hFFF, 8'hA5);
      nextCycle();
      checkOutput("wr_mem_req", mem_req, 1);
      checkOutput("wr_mem_we", mem_we, 1);
      checkOutput("wr_mem_addr", mem_addr, 12'hFFF);
      checkOutput("wr_mem_wdata", mem_wdata, 8'hA5);
      mem_ack = 1'b1;
      nextCycle();
      mem_ack = 1'b0;
      #1;
      checkOutput("wr_resp_stall", dmem_stall, 0);
      checkOutput("wr_resp_mem_req", mem_req, 0);
      checkOutput("wr_data_in_held", d_mem_data_in, 8'h5A);
      checkOutput("wr_stall_cycles", stallCycles - stallBase, 2);
      checkOutput("wr_err", err, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      nextCycle();

      // Read with no ack: request held for exactly 15 REQ cycles, then aborted.
      stallBase = stallCycles;
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h040, 8'h00);
      for (int i = 0; i < 15; i++) begin
         nextCycle();
         checkOutput($sformatf("to_req%0d_mem_req", i + 1), mem_req, 1);
      end
      nextCycle();
      checkOutput("to_resp_mem_req", mem_req, 0);
      checkOutput("to_resp_data", d_mem_data_in, 8'hFF);
      checkOutput("to_resp_err", err, 2'b01);
      checkOutput("to_resp_stall", dmem_stall, 0);
      checkOutput("to_stall_cycles", stallCycles - stallBase, 16);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      err_clr = 1'b1;
      nextCycle();
      err_clr = 1'b0;
      checkOutput("to_err_cleared", err, 0);

      // Enable with no strobe: no access, no stall, protocol error; set beats clear.
      reqBase = reqPulses;
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h055, 8'h00);
      #1;
      checkOutput("nostrobe_stall", dmem_stall, 0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      checkOutput("nostrobe_err", err, 2'b10);
      checkOutput("nostrobe_mem_req", mem_req, 0);
      err_clr = 1'b1;
      nextCycle();
      checkOutput("clr_err", err, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h055, 8'h00);
      nextCycle();
      err_clr = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      checkOutput("set_wins_err", err, 2'b10);
      checkOutput("nostrobe_req_pulses", reqPulses - reqBase, 0);
      err_clr = 1'b1;
      nextCycle();
      err_clr = 1'b0;
      checkOutput("clr_err2", err, 0);

      // rd and wr both high: a single write is issued and the protocol error flags.
      reqBase = reqPulses;
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 8'h3C);
      #1;
      checkOutput("rdwr_idle_stall", dmem_stall, 1);
      nextCycle();
      checkOutput("rdwr_mem_we", mem_we, 1);
      checkOutput("rdwr_mem_addr", mem_addr, 12'h010);
      checkOutput("rdwr_mem_wdata", mem_wdata, 8'h3C);
      checkOutput("rdwr_err", err, 2'b10);
      mem_ack = 1'b1;
      nextCycle();
      mem_ack = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      #1;
      checkOutput("rdwr_resp_mem_req", mem_req, 0);
      checkOutput("rdwr_data_in_held", d_mem_data_in, 8'hFF);
      nextCycle();
      checkOutput("rdwr_req_pulses", reqPulses - reqBase, 1);
      err_clr = 1'b1;
      nextCycle();
      err_clr = 1'b0;
      checkOutput("rdwr_err_cleared", err, 0);

      // Stray ack while idle.
      mem_ack = 1'b1;
      nextCycle();
      mem_ack = 1'b0;
      checkOutput("stray_ack_err", err, 2'b10);
      checkOutput("stray_ack_mem_req", mem_req, 0);
      err_clr = 1'b1;
      nextCycle();
      err_clr = 1'b0;

      // Async reset in the middle of a read, then a late ack.
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h200, 8'h00);
      nextCycle();
      checkOutput("rst_req_mem_req", mem_req, 1);
      reset_ = 1'b0;
      #1;
      checkOutput("rst_async_mem_req", mem_req, 0);
      checkOutput("rst_async_data", d_mem_data_in, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      @(negedge clk);
      reset_ = 1'b1;
      nextCycle();
      checkOutput("rst_after_err", err, 0);
      mem_ack   = 1'b1;
      mem_rdata = 8'h99;
      nextCycle();
      mem_ack   = 1'b0;
      checkOutput("late_ack_err", err, 2'b10);
      checkOutput("late_ack_mem_req", mem_req, 0);
      checkOutput("late_ack_data", d_mem_data_in, 0);
      checkOutput("late_ack_stall", dmem_stall, 0);
      err_clr = 1'b1;
      nextCycle();
      err_clr = 1'b0;

`ifdef DMEM_POSTED_WR_EN
      // Posted write followed at once by a read that waits for the drain.
      applyStimulus(1'b1, 1'b0, 1'b1, 12'h300, 8'h11);
      #1;
      checkOutput("pw_idle_stall", dmem_stall, 0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h301, 8'h00);
      #1;
      checkOutput("pw_req_mem_we", mem_we, 1);
      checkOutput("pw_req_read_stall", dmem_stall, 1);
      nextCycle();
      mem_ack = 1'b1;
      nextCycle();
      mem_ack = 1'b0;
      #1;
      checkOutput("pw_resp_read_stall", dmem_stall, 1);
      nextCycle();
      checkOutput("pw_idle_read_stall", dmem_stall, 1);
      nextCycle();
      checkOutput("pw_read_mem_we", mem_we, 0);
      checkOutput("pw_read_mem_addr", mem_addr, 12'h301);
      mem_ack   = 1'b1;
      mem_rdata = 8'h77;
      nextCycle();
      mem_ack   = 1'b0;
      #1;
      checkOutput("pw_read_data", d_mem_data_in, 8'h77);
      checkOutput("pw_read_resp_stall", dmem_stall, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      nextCycle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
